or_and_reduce_pipe: RTL

- Parametrised, pipelined successor to the flat OR-pair / AND-reduce benchmark logic.
- Each input beat carries NCH channels. Each channel has two W-bit operand vectors A and B.
- Per channel it computes hit = AND over all bits of (A | B), then streams the result out through a valid/ready pipeline.
- It also accumulates a per-channel sticky frame result across a multi-beat frame. Sits between the operand-capture stage and the result collector.

---
 rtl/or_and_reduce_pipe_if.sv | 30 +++
 rtl/or_and_reduce_pipe.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/or_and_reduce_pipe_if.sv
// Operand/result stream bundle for or_and_reduce_pipe.
// master: the side that supplies operand beats and consumes results.
// slave:  the reduction pipeline itself.
interface or_and_reduce_pipe_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned W   = 28
);
    logic             in_valid;
    logic             in_ready;
    logic [NCH*W-1:0] in_a;
    logic [NCH*W-1:0] in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [NCH-1:0]   out_hit;
    logic [NCH-1:0]   out_any;
    logic             out_last;
    logic [NCH-1:0]   out_frame_hit;
    logic             out_overrun;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_hit, out_any, out_last, out_frame_hit, out_overrun
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_hit, out_any, out_last, out_frame_hit, out_overrun
    );
endinterface

// File: rtl/or_and_reduce_pipe.sv
// Pipelined per-channel AND-reduce of (A | B) with per-frame sticky accumulation.
// Stage 0 registers the bitwise OR; each later stage folds the vector by FOLD, and the
// final few bits are ANDed after the last register, so the result is STAGES-independent.
// Optional: define OR_AND_REDUCE_FAILCNT_EN to add per-channel fail counters
// (fail_cnt output, fail_clr input).
module or_and_reduce_pipe #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned W         = 28,
    parameter int unsigned STAGES    = 2,
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned CW        = $clog2(FRAME_LEN + 1)
) (
    input logic             clk,
    input logic             rst,
    or_and_reduce_pipe_if.slave bus
`ifdef OR_AND_REDUCE_FAILCNT_EN
    ,
    input  logic            fail_clr,
    output logic [NCH*16-1:0] fail_cnt
`endif
);

    // Smallest fold factor f with f^s >= w, so s reduction levels reach one bit.
    function automatic int calc_fold(input int w, input int s);
        int f;
        int p;
        f = w;
        for (int cand = w; cand >= 2; cand--) begin
            p = 1;
            for (int k = 0; k < s; k++) begin
                if (p < w) p = p * cand;
            end
            if (p >= w) f = cand;
        end
        return f;
    endfunction

    localparam int FOLD = calc_fold(int'(W), int'(STAGES));

    typedef logic [W-1:0]          vec_t;
    typedef logic [NCH-1:0][W-1:0] beat_t;

    // ANDs groups of FOLD bits into the low positions; vacated bits become 1.
    function automatic vec_t and_fold(input vec_t v);
        vec_t r;
        r = '1;
        for (int i = 0; i < int'(W); i++) begin
            r[i / FOLD] = r[i / FOLD] & v[i];
        end
        return r;
    endfunction

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] last_q;
    logic [STAGES-1:0] adv;
    beat_t             or_q  [STAGES];
    logic [NCH-1:0]    any_q [STAGES];
    beat_t             in_or;

    logic [CW-1:0]  cnt_q;
    logic [NCH-1:0] acc_q;
    logic [NCH-1:0] hit;
    logic           at_limit;
    logic           out_last_w;
    logic           xfer;

    assign in_or = beat_t'(bus.in_a | bus.in_b);

    // Backward advance chain: a stage may move when empty or when its successor moves.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = ~v_q[STAGES-1] | bus.out_ready;
        for (int s = int'(STAGES) - 2; s >= 0; s--) begin
            adv[s] = ~v_q[s] | adv[s+1];
        end
    end

    // Pipeline registers; payload only loads when a valid beat moves in.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            last_q <= '0;
            for (int s = 0; s < int'(STAGES); s++) begin
                or_q[s]  <= '0;
                any_q[s] <= '0;
            end
        end else begin
            if (adv[0]) begin
                v_q[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    or_q[0]   <= in_or;
                    last_q[0] <= bus.in_last;
                    for (int c = 0; c < int'(NCH); c++) begin
                        any_q[0][c] <= in_or[c][0];
                    end
                end
            end
            for (int s = 1; s < int'(STAGES); s++) begin
                if (adv[s]) begin
                    v_q[s] <= v_q[s-1];
                    if (v_q[s-1]) begin
                        last_q[s] <= last_q[s-1];
                        any_q[s]  <= any_q[s-1];
                        for (int c = 0; c < int'(NCH); c++) begin
                            or_q[s][c] <= and_fold(or_q[s-1][c]);
                        end
                    end
                end
            end
        end
    end

    // Final AND level and frame-qualified outputs, all from registered state.
    always_comb begin
        hit = '0;
        for (int c = 0; c < int'(NCH); c++) begin
            hit[c] = &or_q[STAGES-1][c];
        end
        at_limit   = (cnt_q == CW'(FRAME_LEN - 1));
        out_last_w = v_q[STAGES-1] & (last_q[STAGES-1] | at_limit);
        xfer       = v_q[STAGES-1] & bus.out_ready;
    end

    assign bus.in_ready      = adv[0];
    assign bus.out_valid     = v_q[STAGES-1];
    assign bus.out_hit       = hit;
    assign bus.out_any       = any_q[STAGES-1];
    assign bus.out_last      = out_last_w;
    assign bus.out_overrun   = v_q[STAGES-1] & at_limit & ~last_q[STAGES-1];
    assign bus.out_frame_hit = acc_q & hit;

    // Frame accumulator and beat counter, updated only on output transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '1;
        end else if (xfer) begin
            if (out_last_w) begin
                cnt_q <= '0;
                acc_q <= '1;
            end else begin
                cnt_q <= cnt_q + CW'(1);
                acc_q <= acc_q & hit;
            end
        end
    end

`ifdef OR_AND_REDUCE_FAILCNT_EN
    logic [NCH-1:0][15:0] fail_cnt_q;

    // Saturating per-channel fail counts; a clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || fail_clr) begin
            fail_cnt_q <= '0;
        end else if (xfer) begin
            for (int c = 0; c < int'(NCH); c++) begin
                if (!hit[c] && fail_cnt_q[c] != 16'hFFFF) begin
                    fail_cnt_q[c] <= fail_cnt_q[c] + 16'd1;
                end
            end
        end
    end

    assign fail_cnt = fail_cnt_q;
`endif

endmodule
